mux81_rr: RTL

- 8-to-1 round-robin multiplexer; inverse of the 1-to-8 demux.
- Collects words from 8 independent valid/ready source channels and emits them one at a time on a single output stream.
- Each output word carries the 3-bit index of its source channel, so the downstream demux can route it back by driving its sel from out_sel.
- Sits between 8 producers and one shared link; arbitration is fair, with one word accepted per cycle.

---
 rtl/mux81_rr_if.sv | 31 +++
 rtl/mux81_rr.sv | 87 ++++++++
 2 files changed

// File: rtl/mux81_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux81_rr_if
//  Purpose  : Signal bundle for the 8-to-1 round-robin mux: eight valid/ready
//             source channels in, one tagged valid/ready stream out.
//  Revision : 1.0  initial release
// ============================================================================
interface mux81_rr_if #(
    parameter int DATA_W = 8
);
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_valid;
    logic [7:0]          in_ready;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_valid;
    logic                out_ready;

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux81_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux81_rr
//  Purpose  : 8-to-1 round-robin mux with a registered, source-tagged output.
//             Optional macro MUX81_CNT_EN adds a saturating grant counter.
//  Revision : 1.0  initial release
// ============================================================================
module mux81_rr #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mux81_rr_if.slave     bus
`ifdef MUX81_CNT_EN
    ,
    output logic [15:0]   grant_cnt
`endif
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_sel;
    logic [2:0]        r_ptr;

    logic              w_load_ok;
    logic              w_gnt_valid;
    logic [2:0]        w_gnt_idx;
    logic [DATA_W-1:0] w_gnt_data;

    // Gating with rst_n keeps in_ready low for the whole reset assertion.
    assign w_load_ok = rst_n & ((r_state == c_EMPTY) | bus.out_ready);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = r_ptr;
        if (w_load_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (!w_gnt_valid && bus.in_valid[r_ptr + 3'(i)]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = r_ptr + 3'(i);
                end
            end
        end
    end

    assign w_gnt_data   = bus.in_data[w_gnt_idx*DATA_W +: DATA_W];
    assign bus.in_ready = w_gnt_valid ? (8'b1 << w_gnt_idx) : 8'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
            r_data  <= '0;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
        end else if (w_gnt_valid) begin
            r_state <= c_FULL;
            r_data  <= w_gnt_data;
            r_sel   <= w_gnt_idx;
            r_ptr   <= w_gnt_idx + 3'd1;
        end else if (r_state == c_FULL && bus.out_ready) begin
            r_state <= c_EMPTY;
        end
    end

    assign bus.out_valid = (r_state == c_FULL);
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;

`ifdef MUX81_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_gnt_valid && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign grant_cnt = r_cnt;
`endif

endmodule
`default_nettype wire
